// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel duty/enable/mode.
// Period and duty writes land in staging registers and move to the active copies on each wrap.
module pwm_bank #(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 4,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_end
);

    logic [NUM_CH-1:0]              r_out_en;
    logic [NUM_CH-1:0]              r_mode;
    logic [DATA_W-1:0]              r_period_stg;
    logic [DATA_W-1:0]              r_period_act;
    logic [PRESC_W-1:0]             r_prescale;
    logic [PRESC_W-1:0]             r_div;
    logic [DATA_W-1:0]              r_cnt;
    logic                           r_wrap_q;
    logic                           r_period_end;
    logic [NUM_CH-1:0]              r_pwm_out;
    logic [DATA_W-1:0]              r_rd_data;

    logic                           w_tick;
    logic                           w_wrap;
    logic [NUM_CH-1:0]              w_pwm_next;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_duty_stg;
    logic [DATA_W-1:0]              w_rd_next;

    // >= keeps the divider from running past a prescale value lowered mid-count
    assign w_tick = (r_div >= r_prescale);
    assign w_wrap = w_tick && (r_cnt == r_period_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_en     <= '0;
            r_mode       <= '0;
            r_period_stg <= '1;
            r_prescale   <= '0;
        end else if (wr_en) begin
            if (wr_addr == ADDR_W'(0)) r_out_en     <= wr_data[NUM_CH-1:0];
            if (wr_addr == ADDR_W'(1)) r_mode       <= wr_data[NUM_CH-1:0];
            if (wr_addr == ADDR_W'(2)) r_period_stg <= wr_data;
            if (wr_addr == ADDR_W'(3)) r_prescale   <= wr_data[PRESC_W-1:0];
        end
    end

    // period_end goes through two stages so it lines up with the pwm_out cycle for cnt=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= '0;
            r_cnt        <= '0;
            r_period_act <= '1;
            r_wrap_q     <= 1'b0;
            r_period_end <= 1'b0;
        end else if (!ena) begin
            r_div        <= '0;
            r_cnt        <= '0;
            r_period_act <= r_period_stg;
            r_wrap_q     <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_div        <= w_tick ? '0 : r_div + PRESC_W'(1);
            if (w_wrap) begin
                r_cnt        <= '0;
                r_period_act <= r_period_stg;
            end else if (w_tick) begin
                r_cnt        <= r_cnt + DATA_W'(1);
            end
            r_wrap_q     <= w_wrap;
            r_period_end <= r_wrap_q;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] r_duty_stg;
            logic [DATA_W-1:0] r_duty_act;
            logic              w_wr_duty;

            assign w_wr_duty = wr_en && (wr_addr == ADDR_W'(4 + gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_duty_stg <= '0;
                    r_duty_act <= '0;
                end else begin
                    if (w_wr_duty)     r_duty_stg <= wr_data;
                    if (!ena || w_wrap) r_duty_act <= r_duty_stg;
                end
            end

            assign w_duty_stg[gi] = r_duty_stg;
            assign w_pwm_next[gi] = ena && r_out_en[gi] && (!r_mode[gi] || (r_cnt < r_duty_act));
        end
    endgenerate

    always_comb begin
        w_rd_next = '0;
        if (rd_addr == ADDR_W'(0)) w_rd_next[NUM_CH-1:0]  = r_out_en;
        if (rd_addr == ADDR_W'(1)) w_rd_next[NUM_CH-1:0]  = r_mode;
        if (rd_addr == ADDR_W'(2)) w_rd_next              = r_period_stg;
        if (rd_addr == ADDR_W'(3)) w_rd_next[PRESC_W-1:0] = r_prescale;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_addr == ADDR_W'(4 + k)) w_rd_next = w_duty_stg[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_out <= '0;
            r_rd_data <= '0;
        end else begin
            r_pwm_out <= w_pwm_next;
            r_rd_data <= w_rd_next;
        end
    end

    assign pwm_out    = r_pwm_out;
    assign period_end = r_period_end;
    assign rd_data    = r_rd_data;

endmodule
